// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: TDC sequencer state encoding and datapath widths.
package adpll_pkg;

  localparam int TDC_COARSE_W = 5;
  localparam int TDC_FINE_W   = 8;
  localparam int PHASE_ERR_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CAPTURE,
    EMIT,
    RELEASE
  } state_t;

endpackage

// File: rtl/tdc_therm_count.sv
// Fine-code converter: counts tripped stages (zeros) in the active-low thermometer code.
module tdc_therm_count
  import adpll_pkg::*;
#(
  parameter int W = TDC_FINE_W
) (
  input  logic [W-1:0]             trip_b,
  output logic [$clog2(W+1)-1:0]   fine
);

  localparam int CW = $clog2(W + 1);

  // Plain popcount, so bubbles in the thermometer code still yield a stage count.
  always_comb begin
    fine = '0;
    for (int i = 0; i < W; i++) begin
      fine = fine + CW'(~trip_b[i]);
    end
  end

endmodule

// File: rtl/tdc_phase_decoder.sv
// TDC sequencer/decoder: arms the TDC, captures a conversion and emits a signed phase error.
// Optional lock detector compiled in with `define TDC_LOCK_DETECT_EN.
module tdc_phase_decoder
  import adpll_pkg::*;
#(
  parameter int TIMEOUT     = 64,
  parameter int LOCK_THRESH = 2,
  parameter int LOCK_COUNT  = 16
) (
  input  logic                     ref_clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     fine_done_pre,
  input  logic                     early,
  input  logic [TDC_COARSE_W-1:0]  counter_rise,
  input  logic [TDC_COARSE_W-1:0]  counter_fall,
  input  logic [TDC_FINE_W-1:0]    trip_b,
  output logic                     enable_PFD_TDC,
  output logic [PHASE_ERR_W-1:0]   phase_err,
  output logic                     phase_valid,
  output logic                     tdc_err,
  output logic                     timeout,
  output logic                     locked,
  output state_t                   dbg_state
);

  localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int FINE_W = $clog2(TDC_FINE_W + 1);
  localparam int MAG_W  = PHASE_ERR_W - 1;

  state_t                  state, state_nx;
  logic                    sync1, sync2, sync3;
  logic                    done_edge;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    wait_expired;
  logic                    early_q;
  logic [TDC_COARSE_W-1:0] rise_q, fall_q;
  logic [TDC_FINE_W-1:0]   trip_q;
  logic                    bad_q;
  logic [FINE_W-1:0]       fine;
  logic [MAG_W-1:0]        mag;
  logic                    sample_bad;
  logic [PHASE_ERR_W-1:0]  phase_calc;

  assign dbg_state = state;

  // sync3 only serves edge detection, so a level still high on re-entry to WAIT never retriggers.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= fine_done_pre;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign done_edge    = sync2 & ~sync3;
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge ref_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // phase_valid and tdc_err are valid-only strobes (no ready): the loop filter must
  // take phase_err in the strobe cycle; phase_err holds its value between strobes.
  always_comb begin
    state_nx       = state;
    enable_PFD_TDC = 1'b0;
    phase_valid    = 1'b0;
    tdc_err        = 1'b0;
    timeout        = 1'b0;
    case (state)
      IDLE:    if (en) state_nx = WAIT;
      WAIT: begin
        enable_PFD_TDC = 1'b1;
        if (done_edge) begin
          state_nx = CAPTURE;
        end else if (wait_expired) begin
          timeout  = 1'b1;
          state_nx = RELEASE;
        end
      end
      CAPTURE: state_nx = EMIT;
      EMIT: begin
        phase_valid = ~bad_q;
        tdc_err     = bad_q;
        state_nx    = RELEASE;
      end
      RELEASE: state_nx = WAIT;
      default: state_nx = IDLE;
    endcase
    if (!en) begin
      state_nx    = IDLE;
      phase_valid = 1'b0;
      tdc_err     = 1'b0;
      timeout     = 1'b0;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset || state != WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  // TDC data is stable around done, so it is captured without synchronization.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      early_q <= 1'b0;
      rise_q  <= '0;
      fall_q  <= '0;
      trip_q  <= '0;
    end else if (state == WAIT && done_edge) begin
      early_q <= early;
      rise_q  <= counter_rise;
      fall_q  <= counter_fall;
      trip_q  <= trip_b;
    end
  end

  tdc_therm_count #(.W(TDC_FINE_W)) u_therm_count (
    .trip_b (trip_q),
    .fine   (fine)
  );

  assign mag        = MAG_W'({rise_q, 3'b000}) + MAG_W'(fine);
  assign phase_calc = early_q ? {1'b0, mag} : -{1'b0, mag};
  assign sample_bad = ({1'b0, rise_q} > {1'b0, fall_q} + 6'd1) ||
                      ({1'b0, fall_q} > {1'b0, rise_q} + 6'd1);

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      phase_err <= '0;
      bad_q     <= 1'b0;
    end else if (state == CAPTURE) begin
      bad_q <= sample_bad;
      if (en && !sample_bad) phase_err <= phase_calc;
    end
  end

`ifdef TDC_LOCK_DETECT_EN
  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

  logic [LOCK_W-1:0] lock_cnt;
  logic              sample_in_lock;

  assign sample_in_lock = (mag <= MAG_W'(LOCK_THRESH));

  // Updated on the edge that raises the strobe, so locked tracks the emitted sample.
  always_ff @(posedge ref_clk) begin
    if (reset || !en || timeout) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (state == CAPTURE) begin
      if (sample_bad || !sample_in_lock) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else if (lock_cnt != LOCK_W'(LOCK_COUNT)) begin
        lock_cnt <= lock_cnt + 1'b1;
        locked   <= (lock_cnt == LOCK_W'(LOCK_COUNT - 1));
      end
    end
  end
`else
  // Lock thresholds only matter when the detector is built; locked reads constant 0.
  assign locked = (LOCK_COUNT < 0) && (LOCK_THRESH < 0);
`endif

endmodule

// File: tb/tb_tdc_phase_decoder.sv
// Self-checking bench for tdc_phase_decoder: directed corners plus randomized conversions
// checked against a rule-level model; lock checks follow `TDC_LOCK_DETECT_EN.
module tb_tdc_phase_decoder;
  import adpll_pkg::*;

  localparam int TIMEOUT     = 64;
  localparam int LOCK_THRESH = 2;
  localparam int LOCK_COUNT  = 16;
`ifdef TDC_LOCK_DETECT_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic        ref_clk = 1'b0;
  logic        reset, en, fine_done_pre, early;
  logic [4:0]  counter_rise, counter_fall;
  logic [7:0]  trip_b;
  logic        enable_PFD_TDC, phase_valid, tdc_err, timeout, locked;
  logic [9:0]  phase_err;
  state_t      dbg_state;

  tdc_phase_decoder #(
    .TIMEOUT(TIMEOUT), .LOCK_THRESH(LOCK_THRESH), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .ref_clk(ref_clk), .reset(reset), .en(en), .fine_done_pre(fine_done_pre),
    .early(early), .counter_rise(counter_rise), .counter_fall(counter_fall),
    .trip_b(trip_b), .enable_PFD_TDC(enable_PFD_TDC), .phase_err(phase_err),
    .phase_valid(phase_valid), .tdc_err(tdc_err), .timeout(timeout),
    .locked(locked), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 ref_clk = ~ref_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [9:0] exp_q[$];
  logic [9:0] last_phase = '0;
  int         lock_run = 0;
  int         seen_valid = 0, seen_err = 0, seen_timeout = 0;
  int         exp_valid = 0, exp_err = 0, exp_timeout = 0;

  always @(negedge ref_clk) begin
    if (phase_valid) seen_valid++;
    if (tdc_err)     seen_err++;
    if (timeout)     seen_timeout++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int fine_of(input logic [7:0] t);
    int n = 0;
    for (int i = 0; i < 8; i++) if (t[i] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic lock_exp();
    return LOCK_ON && (lock_run >= LOCK_COUNT);
  endfunction

  // driver: called at a negedge in WAIT with fine_done_pre low; returns at a negedge in WAIT
  task automatic convert(input logic e, input logic [4:0] r, input logic [4:0] f,
                         input logic [7:0] t, input int hold);
    int mag, rv, fv;
    bit bad;
    rv = r; fv = f;
    mag = rv * 8 + fine_of(t);
    bad = (rv - fv > 1) || (fv - rv > 1);
    early = e; counter_rise = r; counter_fall = f; trip_b = t;
    fine_done_pre = 1'b1;
    if (!bad) begin
      exp_q.push_back(e ? 10'(mag) : 10'(-mag));
      exp_valid++;
    end else begin
      exp_err++;
    end
    if (bad || mag > LOCK_THRESH) lock_run = 0;
    else if (lock_run < LOCK_COUNT) lock_run++;
    for (int k = 1; k <= 6 || k <= hold; k++) begin
      @(negedge ref_clk);
      if (k == hold) fine_done_pre = 1'b0;
      if (k == 3) check_eq("no_early_strobe", {31'b0, phase_valid | tdc_err}, 32'd0);
      if (k == 4) begin
        check_eq("strobe_valid", {31'b0, phase_valid}, {31'b0, !bad});
        check_eq("strobe_err", {31'b0, tdc_err}, {31'b0, bad});
        if (!bad) last_phase = exp_q.pop_front();
        check_eq("phase_err", {22'b0, phase_err}, {22'b0, last_phase});
        check_eq("locked", {31'b0, locked}, {31'b0, lock_exp()});
      end
      if (k == 5) check_eq("release_low", {31'b0, enable_PFD_TDC}, 32'd0);
      if (k == 6) check_eq("rearm_high", {31'b0, enable_PFD_TDC}, 32'd1);
    end
    if (hold >= 5) repeat (2) @(negedge ref_clk);
  endtask

  // called at the first WAIT negedge; returns at the first WAIT negedge after re-arm
  task automatic expect_timeout();
    int seen_at = -1;
    for (int i = 0; i < 100; i++) begin
      if (timeout) begin
        seen_at = i;
        break;
      end
      @(negedge ref_clk);
    end
    check_eq("timeout_cycle", seen_at, TIMEOUT - 1);
    exp_timeout++;
    lock_run = 0;
    @(negedge ref_clk);
    check_eq("timeout_release", {31'b0, enable_PFD_TDC}, 32'd0);
    check_eq("timeout_lock_clr", {31'b0, locked}, {31'b0, lock_exp()});
    @(negedge ref_clk);
    check_eq("timeout_rearm", {31'b0, enable_PFD_TDC}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_enable"}, {31'b0, enable_PFD_TDC}, 32'd0);
    check_eq({tag, "_phase_err"}, {22'b0, phase_err}, 32'd0);
    check_eq({tag, "_valid"}, {31'b0, phase_valid}, 32'd0);
    check_eq({tag, "_tdc_err"}, {31'b0, tdc_err}, 32'd0);
    check_eq({tag, "_timeout"}, {31'b0, timeout}, 32'd0);
    check_eq({tag, "_locked"}, {31'b0, locked}, 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    logic [4:0] r, f;
    int fi;
    reset = 1'b1; en = 1'b0; fine_done_pre = 1'b0; early = 1'b0;
    counter_rise = '0; counter_fall = '0; trip_b = 8'hFF;
    repeat (3) @(negedge ref_clk);
    check_reset_outputs("reset");

    reset = 1'b0; en = 1'b1;
    @(negedge ref_clk);
    check_eq("first_arm", {31'b0, enable_PFD_TDC}, 32'd1);

    // directed samples: +28, bubble code -28, inconsistent coarse counts
    convert(1'b1, 5'd3, 5'd3, 8'b1111_0000, 2);
    convert(1'b0, 5'd3, 5'd3, 8'b1110_1000, 2);
    convert(1'b1, 5'd7, 5'd4, 8'b1100_0000, 2);

    expect_timeout();

    // done_edge lands exactly on the timeout limit cycle: capture wins
    repeat (TIMEOUT - 3) @(negedge ref_clk);
    convert(1'b0, 5'd31, 5'd30, 8'h00, 1);

    for (int n = 0; n < 40; n++) begin
      r = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) begin
        fi = int'(r) + int'($urandom_range(0, 2)) - 1;
        if (fi < 0) fi = 0;
        if (fi > 31) fi = 31;
        f = 5'(fi);
      end else begin
        f = 5'($urandom_range(0, 31));
      end
      repeat ($urandom_range(0, 5)) @(negedge ref_clk);
      convert(1'($urandom_range(0, 1)), r, f, 8'($urandom), int'($urandom_range(1, 8)));
    end

    // en dropped during CAPTURE: sample discarded, FSM idles
    early = 1'b1; counter_rise = 5'd2; counter_fall = 5'd2; trip_b = 8'h00;
    fine_done_pre = 1'b1;
    @(negedge ref_clk); fine_done_pre = 1'b0;
    @(negedge ref_clk);
    @(negedge ref_clk); en = 1'b0;
    @(negedge ref_clk);
    lock_run = 0;
    check_eq("en_off_state", 32'(dbg_state), 32'(IDLE));
    check_eq("en_off_valid", {31'b0, phase_valid}, 32'd0);
    check_eq("en_off_phase", {22'b0, phase_err}, {22'b0, last_phase});
    check_eq("en_off_locked", {31'b0, locked}, 32'd0);
    en = 1'b1;
    @(negedge ref_clk);
    check_eq("en_on_arm", {31'b0, enable_PFD_TDC}, 32'd1);

    // lock run: 16 samples of |err|=1, then one of +5
    for (int n = 0; n < LOCK_COUNT; n++)
      convert(1'($urandom_range(0, 1)), 5'd0, 5'($urandom_range(0, 1)), 8'hFE, 2);
    convert(1'b1, 5'd0, 5'd0, 8'hE0, 2);

    // reset one cycle after done_edge
    early = 1'b1; counter_rise = 5'd9; counter_fall = 5'd9; trip_b = 8'h0F;
    fine_done_pre = 1'b1;
    @(negedge ref_clk); fine_done_pre = 1'b0;
    @(negedge ref_clk);
    @(negedge ref_clk); reset = 1'b1;
    @(negedge ref_clk);
    last_phase = '0;
    lock_run = 0;
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    @(negedge ref_clk);
    check_eq("post_reset_arm", {31'b0, enable_PFD_TDC}, 32'd1);

    repeat (3) @(negedge ref_clk);
    check_eq("valid_count", seen_valid, exp_valid);
    check_eq("err_count", seen_err, exp_err);
    check_eq("timeout_count", seen_timeout, exp_timeout);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
